// File: rtl/clocked_tdm_mux_pkg.sv
// Shared types and helpers for the clocked TDM multiplexer.
// Holds the FSM state encoding, the channel-index width function and default sizes.
package clocked_tdm_mux_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EMIT     = 2'd1,
      WAIT_REF = 2'd2
   } state_t;

   localparam int WORD_W  = 30;
   localparam int NCH_DEF = 2;
   localparam int FRAME_W = WORD_W * NCH_DEF;

   function automatic int cw_f(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/clocked_tdm_mux_if.sv
// Frame-in / beat-out handshake bundle of the TDM multiplexer.
// master drives in_data/in_valid/out_ready; slave (the mux) drives the rest.
interface clocked_tdm_mux_if
   import clocked_tdm_mux_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int NCH   = NCH_DEF
);
   localparam int CW = cw_f(NCH);

   logic [NCH*WIDTH-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     out_data;
   logic [CW-1:0]        out_chan;
   logic                 out_last;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_chan, out_last, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_chan, out_last, out_valid
   );

endinterface

// File: rtl/tdm_frame_buf.sv
// One frame register with a full flag; load wins over clear.
// Ports: clk, reset_n (sync, active-low), load, clear, d -> q, full.
module tdm_frame_buf #(
   parameter int FRAME_W = 60
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic               clear,
   input  logic [FRAME_W-1:0] d,
   output logic [FRAME_W-1:0] q,
   output logic               full
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q    <= '0;
         full <= 1'b0;
      end else if (load) begin
         q    <= d;
         full <= 1'b1;
      end else if (clear) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/clocked_tdm_mux.sv
// N-channel TDM mux: accepts NCH-word frames, emits one word per beat, ch 0 first.
// Ports: fast_clock, reset_n (sync, active-low), slow_ref, bus (slave modport).
// Macro CLOCKED_TDM_MUX_ALIGN_EN: each frame waits for a slow_ref rise before emitting.
module clocked_tdm_mux
   import clocked_tdm_mux_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int NCH   = NCH_DEF
) (
   input  logic             fast_clock,
   input  logic             reset_n,
   input  logic             slow_ref,
   clocked_tdm_mux_if.slave bus
);

   localparam int CW = cw_f(NCH);
   localparam int FW = NCH * WIDTH;
   localparam logic [CW-1:0] LAST = CW'(NCH - 1);

   logic [FW-1:0]    sh_data;
   logic [FW-1:0]    act_data;
   logic             sh_full;
   logic             act_full;
   logic             sh_load;
   logic             accept;
   logic             last_acc;
   logic             promote;
   logic             drain;
   state_t           state_q;
   state_t           state_d;
   state_t           go_state;
   logic [CW-1:0]    idx_q;
   logic [CW-1:0]    idx_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             last_q;
   logic             last_d;
   logic             valid_q;

`ifdef CLOCKED_TDM_MUX_ALIGN_EN
   logic ref_q1;
   logic ref_q2;
   logic rise;

   always_ff @(posedge fast_clock) begin
      if (!reset_n) begin
         ref_q1 <= 1'b0;
         ref_q2 <= 1'b0;
      end else begin
         ref_q1 <= slow_ref;
         ref_q2 <= ref_q1;
      end
   end

   assign rise     = ref_q1 & ~ref_q2;
   assign go_state = WAIT_REF;
`else
   logic unused_ref;

   assign unused_ref = slow_ref;
   assign go_state   = EMIT;
`endif

   tdm_frame_buf #(.FRAME_W(FW)) u_shadow (
      .clk     (fast_clock),
      .reset_n (reset_n),
      .load    (sh_load),
      .clear   (promote),
      .d       (bus.in_data),
      .q       (sh_data),
      .full    (sh_full)
   );

   tdm_frame_buf #(.FRAME_W(FW)) u_active (
      .clk     (fast_clock),
      .reset_n (reset_n),
      .load    (promote),
      .clear   (drain),
      .d       (sh_data),
      .q       (act_data),
      .full    (act_full)
   );

   always_comb begin
      sh_load  = bus.in_valid & ~sh_full;
      accept   = valid_q & bus.out_ready;
      last_acc = accept & (idx_q == LAST);
      // active is free either when empty or when its final beat leaves now
      promote  = sh_full & (~act_full | last_acc);
      drain    = last_acc & ~promote;

      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (promote) state_d = go_state;
         end
         EMIT: begin
            if (promote)       state_d = go_state;
            else if (last_acc) state_d = IDLE;
         end
`ifdef CLOCKED_TDM_MUX_ALIGN_EN
         WAIT_REF: begin
            if (rise) state_d = EMIT;
         end
`endif
         default: state_d = IDLE;
      endcase

      idx_d  = idx_q;
      data_d = data_q;
      last_d = last_q;
      if (promote) begin
         idx_d  = '0;
         data_d = sh_data[WIDTH-1:0];
         last_d = (NCH == 1);
      end else if (accept && !last_acc) begin
         // idx holds at NCH-1 on drain; only promote wraps it
         idx_d  = idx_q + CW'(1);
         data_d = act_data[int'(idx_d)*WIDTH +: WIDTH];
         last_d = (idx_d == LAST);
      end
   end

   always_ff @(posedge fast_clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         last_q  <= last_d;
         valid_q <= (state_d == EMIT);
      end
   end

   assign bus.in_ready  = ~sh_full;
   assign bus.out_data  = data_q;
   assign bus.out_chan  = idx_q;
   assign bus.out_last  = last_q;
   assign bus.out_valid = valid_q;

endmodule
